regfile_2r1w_sb: RTL
====================

Name: regfile_2r1w_sb

Overview:
- Parametrised successor to the 16x16 register bank.
- Provides a WIDTH x DEPTH register file with one write port and two addressed, registered read ports.
- Includes write-to-read bypass, an optional hardwired-zero register 0, and a per-register busy scoreboard for pipeline hazard detection.
- Sits between decode/execute and the ALU operand muxes; its read outputs feed the A/B operand paths directly.

Parameters:
- WIDTH, 16, data width of each register.
- DEPTH, 16, number of registers; need not be a power of two.
- AW, $clog2(DEPTH), address width.
- ZERO_REG, 0, when 1 register 0 always reads 0 and ignores writes and reservations.
- BYPASS, 1, when 1 a same-cycle write is forwarded into a matching read capture.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write register index.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  capture strobe for both read ports.
- rd_addr_a  in  AW  read port A index.
- rd_addr_b  in  AW  read port B index.
- rsv_en  in  1  reserve strobe; marks a destination as pending.
- rsv_addr  in  AW  register index to reserve.
- rd_data_a  out  WIDTH  registered port A data.
- rd_data_b  out  WIDTH  registered port B data.
- busy_a  out  1  registered busy flag for the captured A address.
- busy_b  out  1  registered busy flag for the captured B address.
- stall  out  1  combinational hazard flag for the current read addresses.
- busy_vec  out  DEPTH  scoreboard contents, bit i = register i pending.

Behaviour:
- Reset is asynchronous and active-low.
  - While reset=0: all registers, rd_data_a/b, busy_a/b and busy_vec are 0.
  - stall is 0 while reset=0.
  - Deassertion takes effect at the next rising edge. There is no partial state after reset mid-operation.
- Write: at posedge, if wr_en and wr_addr<DEPTH, mem[wr_addr] <= wr_data.
  - Ignored when wr_addr>=DEPTH.
  - Ignored when ZERO_REG=1 and wr_addr=0.
- Read: 1-cycle latency.
  - At posedge with rd_en=1: rd_data_x <= src_x, where src_x is one of:
    - 0 if addr>=DEPTH, or if ZERO_REG=1 and addr=0;
    - else wr_data if BYPASS=1, wr_en=1 and wr_addr=addr (write accepted);
    - else mem[addr].
  - With BYPASS=0 the capture returns the old mem contents; the new value is visible on the next capture.
  - rd_en=0: rd_data_a/b and busy_a/b hold their values.
  - Ports A and B are independent. Both may address the same register and both then return the same value.
- Scoreboard update, per bit i at posedge:
  - set if rsv_en and rsv_addr=i;
  - else clear if wr_en and wr_addr=i;
  - else hold.
  - Simultaneous reserve and write to the same register: set wins, because a new producer is in flight. The data write still occurs.
  - Reserving an already-busy register keeps it busy. There is no counting.
  - Reservation to addr>=DEPTH, or to 0 with ZERO_REG=1, is ignored.
- Effective busy for address x: eb(x) = busy_vec[x] & ~(wr_en & wr_addr==x).
  - The write completing this cycle resolves the hazard.
  - A same-cycle reservation does not count toward eb(x).
  - eb(x) is 0 for out-of-range addresses and for the zero register.
- stall = rd_en & (eb(rd_addr_a) | eb(rd_addr_b)). Purely combinational, no state.
- busy_a/b <= eb(rd_addr_a/b) on a capture (rd_en=1), in the same cycle as the corresponding rd_data.
- Write strobes have no back-pressure. Every accepted write completes in one cycle.

Test Plan:
- Reset with all inputs toggling -> every output reads 0. Release, write 0x1234 to r5, capture A=5 -> rd_data_a=0x1234 one cycle later.
- BYPASS=1: same cycle wr_en r3=0xBEEF with rd_en A=3, B=3 -> both ports return 0xBEEF next cycle. Repeat with BYPASS=0 -> both return the old r3 value (0).
- ZERO_REG=1: write 0xFFFF to r0, reserve r0, capture A=0 -> rd_data_a=0, busy_a=0, busy_vec[0]=0. With ZERO_REG=0 the same sequence returns 0xFFFF.
- Scoreboard: rsv r7 -> busy_vec=0x0080. rd_en A=7 -> stall=1. Next cycle wr r7 with rd_en A=7 -> stall=0, busy_a=0, busy_vec=0x0000.
- Simultaneous rsv_en and wr_en to r9 with 0x0042 -> busy_vec[9]=1 and a subsequent read of r9 returns 0x0042.
- DEPTH=12: write to addr 13 -> no register changes. Read of addr 13 -> 0. Assert reset mid-sequence with busy bits set -> busy_vec=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_2r1w_sb.sv
// Parametrised register file: one write port, two registered read ports, write-to-read
// bypass, optional hardwired-zero r0 and a per-register busy scoreboard for hazard stalls.
module regfile_2r1w_sb #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             busy_a,
    output logic             busy_b,
    output logic             stall,
    output logic [DEPTH-1:0] busy_vec
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    // An address is live only if it exists and is not the hardwired zero register.
    function automatic logic addrValid(input logic [AW-1:0] addr);
        return ({1'b0, addr} < DEPTH_W) && !((ZERO_REG != 0) && (addr == '0));
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wrOk;
    logic             rsvOk;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             ebA;
    logic             ebB;

    // A write landing this cycle resolves the hazard on its register; a same-cycle
    // reservation only becomes visible from the next cycle on.
    always_comb begin
        wrOk  = wr_en & addrValid(wr_addr);
        rsvOk = rsv_en & addrValid(rsv_addr);

        srcA = '0;
        if (addrValid(rd_addr_a)) begin
            if ((BYPASS != 0) && wrOk && (wr_addr == rd_addr_a)) srcA = wr_data;
            else                                                 srcA = mem[rd_addr_a];
        end

        srcB = '0;
        if (addrValid(rd_addr_b)) begin
            if ((BYPASS != 0) && wrOk && (wr_addr == rd_addr_b)) srcB = wr_data;
            else                                                 srcB = mem[rd_addr_b];
        end

        ebA   = addrValid(rd_addr_a) & busy_vec[rd_addr_a] & ~(wrOk & (wr_addr == rd_addr_a));
        ebB   = addrValid(rd_addr_b) & busy_vec[rd_addr_b] & ~(wrOk & (wr_addr == rd_addr_b));
        stall = rd_en & (ebA | ebB);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wrOk) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reservation beats a same-cycle write: a newer producer is already in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_vec <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rsvOk && (rsv_addr == AW'(i)))    busy_vec[i] <= 1'b1;
                else if (wrOk && (wr_addr == AW'(i))) busy_vec[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
            busy_a    <= 1'b0;
            busy_b    <= 1'b0;
        end else if (rd_en) begin
            rd_data_a <= srcA;
            rd_data_b <= srcB;
            busy_a    <= ebA;
            busy_b    <= ebB;
        end
    end

endmodule
